// File: rtl/unidade_desvio.sv
// Branch resolution stage: resolves BEQ/BNE through a two-slot (E -> S) backpressured
// pipeline, producing taken decision, next PC, misprediction flush and an error count.
//
// state | meaning
// VAZIO | both stages empty
// SO_E  | only E (compare) holds an instruction
// SO_S  | only S (output) holds a result
// CHEIO | both stages occupied
module unidade_desvio #(
  parameter int LARG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ent_valido,
  output logic            ent_pronto,
  input  logic            ent_op,
  input  logic [LARG-1:0] ent_a,
  input  logic [LARG-1:0] ent_b,
  input  logic [LARG-1:0] ent_pc,
  input  logic [LARG-1:0] ent_offset,
  input  logic            ent_pred,
  output logic            sai_valido,
  input  logic            sai_pronto,
  output logic            sai_tomado,
  output logic [LARG-1:0] sai_alvo,
  output logic            sai_flush,
  output logic [7:0]      cont_erro
);

  // Encoding chosen so bit 0 is E occupancy and bit 1 is S occupancy.
  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    SO_E  = 2'b01,
    SO_S  = 2'b10,
    CHEIO = 2'b11
  } estado_t;

  estado_t         estado;
  estado_t         estado_prox;

  logic            e_op;
  logic [LARG-1:0] e_a;
  logic [LARG-1:0] e_b;
  logic [LARG-1:0] e_pc;
  logic [LARG-1:0] e_offset;
  logic            e_pred;

  logic            valido_e;
  logic            valido_s;
  logic            igual;
  logic            e_tomado;
  logic [LARG-1:0] pc_seq;
  logic [LARG-1:0] e_alvo;
  logic            e_flush;

  logic            sai_transf;
  logic            squash;
  logic            avanco;
  logic            aceita;
  logic            prox_e;
  logic            prox_s;

  assign valido_e = estado[0];
  assign valido_s = estado[1];

  assign igual    = &(e_a ~^ e_b);
  assign e_tomado = igual ^ e_op;
  assign pc_seq   = e_pc + LARG'(1);
  assign e_alvo   = e_tomado ? pc_seq + e_offset : pc_seq;
  assign e_flush  = e_tomado ^ e_pred;

  // A flushing result leaving S means whatever sits in E came from the wrong path.
  assign sai_transf = valido_s & sai_pronto;
  assign squash     = sai_transf & sai_flush;
  assign avanco     = valido_e & (~valido_s | sai_pronto) & ~squash;
  assign ent_pronto = ~squash & (~valido_e | avanco);
  assign aceita     = ent_valido & ent_pronto;

  assign prox_e = aceita | (valido_e & ~avanco);
  assign prox_s = avanco | (valido_s & ~sai_transf);

  always_comb begin
    estado_prox = estado;
    if (squash) begin
      estado_prox = VAZIO;
    end else begin
      estado_prox = estado_t'({prox_s, prox_e});
    end
  end

  assign sai_valido = valido_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= VAZIO;
      e_op       <= 1'b0;
      e_a        <= '0;
      e_b        <= '0;
      e_pc       <= '0;
      e_offset   <= '0;
      e_pred     <= 1'b0;
      sai_tomado <= 1'b0;
      sai_alvo   <= '0;
      sai_flush  <= 1'b0;
      cont_erro  <= 8'd0;
    end else begin
      estado <= estado_prox;
      if (aceita) begin
        e_op     <= ent_op;
        e_a      <= ent_a;
        e_b      <= ent_b;
        e_pc     <= ent_pc;
        e_offset <= ent_offset;
        e_pred   <= ent_pred;
      end
      if (avanco) begin
        sai_tomado <= e_tomado;
        sai_alvo   <= e_alvo;
        sai_flush  <= e_flush;
      end
      if (squash && cont_erro != 8'hFF) begin
        cont_erro <= cont_erro + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_unidade_desvio.sv
// Self-checking bench for unidade_desvio: table-driven vectors and hand-written
// sequences, with expected results queued at input accept and compared at output.
module tb_unidade_desvio;

  typedef struct packed {
    logic       tomado;
    logic [7:0] alvo;
    logic       flush;
  } res_t;

  typedef struct packed {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pc;
    logic [7:0] off;
    logic       pred;
    res_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ent_valido = 1'b0;
  logic       ent_pronto;
  logic       ent_op = 1'b0;
  logic [7:0] ent_a = 8'd0;
  logic [7:0] ent_b = 8'd0;
  logic [7:0] ent_pc = 8'd0;
  logic [7:0] ent_offset = 8'd0;
  logic       ent_pred = 1'b0;
  logic       sai_valido;
  logic       sai_pronto = 1'b1;
  logic       sai_tomado;
  logic [7:0] sai_alvo;
  logic       sai_flush;
  logic [7:0] cont_erro;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   exp_cont = 0;
  res_t cur_exp;
  res_t sb[$];
  logic stall_prev = 1'b0;
  logic held_tomado, held_flush;
  logic [7:0] held_alvo;
  logic rnd_done;

  vec_t tab[6];

  unidade_desvio #(.LARG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ent_valido(ent_valido), .ent_pronto(ent_pronto), .ent_op(ent_op),
    .ent_a(ent_a), .ent_b(ent_b), .ent_pc(ent_pc), .ent_offset(ent_offset),
    .ent_pred(ent_pred),
    .sai_valido(sai_valido), .sai_pronto(sai_pronto), .sai_tomado(sai_tomado),
    .sai_alvo(sai_alvo), .sai_flush(sai_flush), .cont_erro(cont_erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  function automatic res_t modelo(input vec_t v);
    res_t r;
    logic [7:0] seq;
    seq = v.pc + 8'd1;
    r.tomado = (v.a == v.b) ? ~v.op : v.op;
    r.alvo = r.tomado ? seq + v.off : seq;
    r.flush = (r.tomado != v.pred);
    return r;
  endfunction

  function automatic vec_t mk(input logic op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] pc, input logic [7:0] off, input logic pred,
                              input logic t, input logic [7:0] al, input logic f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.pc = pc; v.off = off; v.pred = pred;
    v.exp.tomado = t; v.exp.alvo = al; v.exp.flush = f;
    return v;
  endfunction

  function automatic vec_t mkm(input logic op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] pc, input logic [7:0] off, input logic pred);
    vec_t v;
    v = mk(op, a, b, pc, off, pred, 1'b0, 8'd0, 1'b0);
    v.exp = modelo(v);
    return v;
  endfunction

  // Monitor: handshakes are evaluated at the falling edge, ahead of the edge that commits them.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      chk("cont_erro", 32'(cont_erro), 32'(exp_cont));
      if (stall_prev) begin
        chk("hold_valido", 32'(sai_valido), 32'd1);
        chk("hold_tomado", 32'(sai_tomado), 32'(held_tomado));
        chk("hold_alvo", 32'(sai_alvo), 32'(held_alvo));
        chk("hold_flush", 32'(sai_flush), 32'(held_flush));
      end
      stall_prev = sai_valido && !sai_pronto;
      held_tomado = sai_tomado;
      held_alvo = sai_alvo;
      held_flush = sai_flush;
      if (sai_valido && sai_pronto) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(sai_alvo), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_tomado", 32'(sai_tomado), 32'(e.tomado));
          chk("out_alvo", 32'(sai_alvo), 32'(e.alvo));
          chk("out_flush", 32'(sai_flush), 32'(e.flush));
          if (e.flush) begin
            chk("squash_ent_pronto", 32'(ent_pronto), 32'd0);
            sb.delete();
            if (exp_cont != 255) exp_cont++;
          end
        end
      end
      if (ent_valido && ent_pronto) begin
        sb.push_back(cur_exp);
        n_acc++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic sinc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ent_op = v.op; ent_a = v.a; ent_b = v.b; ent_pc = v.pc;
    ent_offset = v.off; ent_pred = v.pred; cur_exp = v.exp;
    ent_valido = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted v.
  task automatic send(input vec_t v);
    int t;
    t = 0;
    drive(v);
    @(negedge clk);
    while (!ent_pronto && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!ent_pronto) begin
      chk("send_timeout", 32'(ent_pronto), 32'd1);
      ent_valido = 1'b0;
    end
    sinc();
  endtask

  task automatic drenar();
    int t;
    t = 0;
    ent_valido = 1'b0;
    sai_pronto = 1'b1;
    @(negedge clk);
    while ((sb.size() != 0 || sai_valido) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
    chk("drain_valido", 32'(sai_valido), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t vbp[4];
    int acc0;

    tab[0] = mk(1'b0, 8'h3C, 8'h3C, 8'h10, 8'h05, 1'b1, 1'b1, 8'h16, 1'b0);
    tab[1] = mk(1'b1, 8'h00, 8'h00, 8'hFF, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
    tab[2] = mk(1'b0, 8'h55, 8'h55, 8'h04, 8'hFA, 1'b1, 1'b1, 8'hFF, 1'b0);
    tab[3] = mk(1'b1, 8'h12, 8'h34, 8'h20, 8'hF0, 1'b1, 1'b1, 8'h11, 1'b0);
    tab[4] = mk(1'b0, 8'h80, 8'h00, 8'h7F, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0);
    tab[5] = mk(1'b1, 8'hAA, 8'hAB, 8'h00, 8'h7F, 1'b1, 1'b1, 8'h80, 1'b0);

    // Reset with random inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sinc();
      ent_valido = 1'($urandom_range(0, 1));
      ent_op = 1'($urandom_range(0, 1));
      ent_a = 8'($urandom); ent_b = 8'($urandom);
      ent_pc = 8'($urandom); ent_offset = 8'($urandom);
      ent_pred = 1'($urandom_range(0, 1));
      sai_pronto = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_valido", 32'(sai_valido), 32'd0);
    end
    chk("rst_tomado", 32'(sai_tomado), 32'd0);
    chk("rst_alvo", 32'(sai_alvo), 32'd0);
    chk("rst_flush", 32'(sai_flush), 32'd0);
    chk("rst_cont", 32'(cont_erro), 32'd0);
    ent_valido = 1'b0;
    sai_pronto = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ent_pronto", 32'(ent_pronto), 32'd1);

    // Latency: accepted at edge N, valid after edge N+1
    sinc();
    send(tab[0]);
    ent_valido = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", 32'(sai_valido), 32'd0);
    @(negedge clk);
    chk("lat_valido", 32'(sai_valido), 32'd1);
    drenar();

    // Table stream, back to back
    sinc();
    for (int i = 0; i < 6; i++) send(tab[i]);
    drenar();

    // Backpressure: 4 branches, consumer stalled for 5 cycles
    for (int i = 0; i < 4; i++)
      vbp[i] = mkm(i[0], 8'(i), 8'(i), 8'(8'h40 + 8'(i * 16)), 8'(i + 1), ~i[0]);
    sinc();
    sai_pronto = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vbp[i]);
        ent_valido = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
        chk("bp_ent_pronto", 32'(ent_pronto), 32'd0);
        repeat (2) @(negedge clk);
        sinc();
        sai_pronto = 1'b1;
      end
    join
    drenar();
    chk("bp_total", 32'(n_acc - acc0), 32'd4);

    // Misprediction squash with a wrong-path follower
    sinc();
    send(mkm(1'b0, 8'h01, 8'h02, 8'h30, 8'h08, 1'b1));
    send(mkm(1'b0, 8'h09, 8'h09, 8'h50, 8'h02, 1'b1));
    drive(mkm(1'b1, 8'h07, 8'h08, 8'h60, 8'h03, 1'b1));
    @(negedge clk);
    chk("sq_flush", 32'(sai_flush), 32'd1);
    chk("sq_pronto_low", 32'(ent_pronto), 32'd0);
    @(negedge clk);
    chk("sq_pronto_next", 32'(ent_pronto), 32'd1);
    sinc();
    ent_valido = 1'b0;
    drenar();
    chk("sq_cont", 32'(cont_erro), 32'd1);

    // Random stream with random consumer stalls
    rnd_done = 1'b0;
    sinc();
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          v.op = 1'($urandom_range(0, 1));
          v.a = 8'($urandom);
          v.b = ($urandom_range(0, 1) == 1) ? v.a : 8'($urandom);
          v.pc = 8'($urandom);
          v.off = 8'($urandom);
          v.pred = 1'($urandom_range(0, 1));
          v.exp = modelo(v);
          send(v);
        end
        ent_valido = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          sai_pronto = 1'($urandom_range(0, 1));
          sinc();
        end
        sai_pronto = 1'b1;
      end
    join
    drenar();

    // Saturation: well over 255 delivered mispredictions
    sinc();
    for (int i = 0; i < 600; i++)
      send(mkm(1'b0, 8'h01, 8'h02, 8'(i), 8'h03, 1'b1));
    drenar();
    chk("sat_cont", 32'(cont_erro), 32'd255);

    // Mid-run reset while CHEIO
    sinc();
    sai_pronto = 1'b0;
    send(tab[1]);
    send(tab[2]);
    ent_valido = 1'b0;
    @(negedge clk);
    chk("cheio_pronto", 32'(ent_pronto), 32'd0);
    chk("cheio_valido", 32'(sai_valido), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valido", 32'(sai_valido), 32'd0);
    chk("mrst_cont", 32'(cont_erro), 32'd0);
    chk("mrst_alvo", 32'(sai_alvo), 32'd0);
    sb.delete();
    exp_cont = 0;
    repeat (2) sinc();
    sai_pronto = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pronto", 32'(ent_pronto), 32'd1);
    chk("post_rst_valido", 32'(sai_valido), 32'd0);
    sinc();
    send(tab[3]);
    drenar();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
